fp_add_scheduler: RTL and testbench
===================================

# fp_add_scheduler

Round-robin scheduler that shares one `FloatingPointAdder` instance between `NREQ` independent requesters. It sits between the requesters and the adder, and owns the adder's `Go`/`Ready` handshake. Per operation it does four things: grants one requester, drives its operands onto the adder, waits for `Ready` under a timeout, and returns the registered result and flags to the granted requester with a one-cycle `Done` pulse.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters (2..16).
- `TIMEOUT`, default 64: maximum WAIT cycles before an operation is abandoned.

Ports:
- `Clock` in 1: single clock, rising-edge.
- `Reset` in 1: synchronous, active-high.
- `Req` in `NREQ`: per-requester level request. Held with operands stable until the matching `Done`.
- `ReqA` in `NREQ` x `float`: per-requester addend A (`float` = {sign, exp[7:0], frac[22:0]}, 32 bits).
- `ReqB` in `NREQ` x `float`: per-requester addend B.
- `Grant` out `NREQ`: one-hot owner of the adder. All zeros when idle.
- `Done` out `NREQ`: one-cycle completion pulse to the owner.
- `Result` out `float`: registered sum. Valid while any `Done` bit is high.
- `Zero`, `Inf`, `Nan` out 1 each: registered adder flags. Valid with `Done`.
- `TimedOut` out 1: qualifies `Done`. High means the operation was abandoned.
- `Busy` out 1: high in every state except IDLE.
- `AdderA`, `AdderB` out `float`: to adder `AddendA`/`AddendB`.
- `AdderGo` out 1: to adder `Go`.
- `AdderResult` in `float`, `AdderReady` in 1, `AdderZero`/`AdderInf`/`AdderNan` in 1: from the adder.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any `Req` bit is set, pick the winner by round robin from the current priority pointer.
  - Register the winner's index and copy its `ReqA`/`ReqB` into `AdderA`/`AdderB`.
  - Set `Grant`, then go to ISSUE.
- ISSUE:
  - `AdderGo`=1 for one cycle, with `AdderA`/`AdderB` held.
  - `AdderReady` is ignored in this state (guards against a stale `Ready`).
  - Always go to WAIT.
- WAIT:
  - `AdderGo` stays 1 and the timeout counter increments each cycle.
  - If `AdderReady`=1: capture `AdderResult` and the flags, set `TimedOut`=0, go to RESPOND.
  - Else if the counter reaches `TIMEOUT`: set `Result`=0 and `Zero`/`Inf`/`Nan`=0, set `TimedOut`=1, go to RESPOND.
- RESPOND:
  - `AdderGo`=0. `Done[owner]`=1 for exactly one cycle.
  - Priority pointer becomes owner+1, wrapping at `NREQ` (mod `NREQ`).
  - Next state is IDLE, where `Grant` clears.
- Operands are sampled once, at the IDLE-to-ISSUE transition. Requester changes after the grant have no effect.
- A requester that still holds `Req` in the cycle after its `Done` is treated as a new request. It ranks lowest under the rotated pointer.
- `Req` bits that drop before being granted are simply not served. Dropping `Req` after grant does not abort the operation.
- If `AdderReady` and the timeout arrive on the same cycle, `Ready` wins (`TimedOut`=0).
- Counter width is `$clog2(TIMEOUT+1)`. The counter clears on entry to ISSUE.

## Timing
- Reset values:
  - State: IDLE. Pointer: 0. Counter: 0.
  - `Grant`, `Done`: 0. `Result`: 0. `Zero`, `Inf`, `Nan`, `TimedOut`: 0.
  - `Busy`, `AdderGo`: 0. `AdderA`, `AdderB`: 0.
- Reset asserted in any state, including mid-WAIT:
  - The operation is aborted at that edge: IDLE, `AdderGo`=0, no `Done` issued.
  - The requester must re-request.
- Latency, request seen in IDLE at edge t:
  - ISSUE at t+1; WAIT from t+2.
  - `AdderReady` sampled at edge r puts `Done` high in cycle r+1.
  - Scheduler is back in IDLE at r+2.
  - Minimum request-to-`Done` is 3 cycles plus the adder latency.
- Throughput: at most one operation per (adder latency + 3) cycles. No back-to-back overlap.
- Timeout: `Done` with `TimedOut`=1 occurs exactly `TIMEOUT`+1 cycles after WAIT entry.

## Structure
- Add to `floatingpointpkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} fpsched_state_t;`
  - The `FPSCHED_DEFAULT_TIMEOUT` constant.
- Reuse the existing `float` typedef from `floatingpointpkg`.
- Sub-module `rr_pick`: combinational, parameterised by `NREQ`. Inputs: `Req` vector and pointer. Outputs: one-hot winner and its index. Instantiated once.

## Test plan
- Single requester 0 sends A=0x3F800000 (1.0) and B=0x40000000 (2.0) → `Done[0]` pulses once, `Result`=0x40400000, all flags 0, `TimedOut`=0. Latency equals adder latency + 3.
- Requesters 1 and 3 raise `Req` on the same edge from reset (pointer 0) → requester 1 is served first, then 3. The pointer ends at 0 (3+1 wraps mod 4). Each receives its own sum.
- A=0x80000000 (-0) and B=0x00000000 (+0) → `Zero`=1, `Result` sign/exp/frac = 0.
- A=B=0x7F7FFFFF → `Inf`=1, `Result`=0x7F800000.
- Stub adder with `Ready` tied 0 and `TIMEOUT`=16 → `Done` with `TimedOut`=1 and `Result`=0 exactly 17 cycles after WAIT entry. Next request is granted normally.
- `Reset` pulsed while in WAIT → next cycle in IDLE, `AdderGo`=0, `Grant`=0, no `Done` ever issued for the aborted operation.

Source files
------------

// File: rtl/floatingpointpkg.sv
// Shared floating-point types plus the scheduler's state encoding and default timeout.
package floatingpointpkg;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] frac;
    } float;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} fpsched_state_t;

    localparam int unsigned FPSCHED_DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/fp_add_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         win_o,
    output logic [$clog2(NREQ)-1:0] idx_o
);

    localparam int unsigned IW = $clog2(NREQ);

    logic          found;
    int unsigned   slot;
    logic [IW-1:0] slot_idx;

    always_comb begin
        win_o    = '0;
        idx_o    = '0;
        found    = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            slot     = (32'(ptr_i) + i) % NREQ;
            slot_idx = IW'(slot);
            if (!found && req_i[slot_idx]) begin
                found           = 1'b1;
                win_o[slot_idx] = 1'b1;
                idx_o           = slot_idx;
            end
        end
    end

endmodule

// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one FloatingPointAdder between NREQ requesters.
// Owns the adder Go/Ready handshake and returns a registered result with a one-cycle Done.
module fp_add_scheduler
    import floatingpointpkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = FPSCHED_DEFAULT_TIMEOUT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NREQ-1:0]   Req,
    input  float [NREQ-1:0]   ReqA,
    input  float [NREQ-1:0]   ReqB,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   Done,
    output float              Result,
    output logic              Zero,
    output logic              Inf,
    output logic              Nan,
    output logic              TimedOut,
    output logic              Busy,
    output float              AdderA,
    output float              AdderB,
    output logic              AdderGo,
    input  float              AdderResult,
    input  logic              AdderReady,
    input  logic              AdderZero,
    input  logic              AdderInf,
    input  logic              AdderNan
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    fpsched_state_t  state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    float            result_q, result_d;
    logic            zero_q, zero_d;
    logic            inf_q, inf_d;
    logic            nan_q, nan_d;
    logic            timedout_q, timedout_d;
    float            adder_a_q, adder_a_d;
    float            adder_b_q, adder_b_d;

    logic [NREQ-1:0] pick_win;
    logic [IW-1:0]   pick_idx;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req_i (Req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            done_q     <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            inf_q      <= 1'b0;
            nan_q      <= 1'b0;
            timedout_q <= 1'b0;
            adder_a_q  <= '0;
            adder_b_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            inf_q      <= inf_d;
            nan_q      <= nan_d;
            timedout_q <= timedout_d;
            adder_a_q  <= adder_a_d;
            adder_b_q  <= adder_b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        done_d     = '0;
        result_d   = result_q;
        zero_d     = zero_q;
        inf_d      = inf_q;
        nan_d      = nan_q;
        timedout_d = timedout_q;
        adder_a_d  = adder_a_q;
        adder_b_d  = adder_b_q;

        unique case (state_q)
            IDLE: begin
                if (|Req) begin
                    grant_d   = pick_win;
                    owner_d   = pick_idx;
                    adder_a_d = ReqA[pick_idx];
                    adder_b_d = ReqB[pick_idx];
                    cnt_d     = '0;
                    state_d   = ISSUE;
                end
            end
            // Ready is deliberately not looked at here; it may be left over from the last op.
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (AdderReady) begin
                    result_d   = AdderResult;
                    zero_d     = AdderZero;
                    inf_d      = AdderInf;
                    nan_d      = AdderNan;
                    timedout_d = 1'b0;
                    done_d     = grant_q;
                    state_d    = RESPOND;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    result_d   = '0;
                    zero_d     = 1'b0;
                    inf_d      = 1'b0;
                    nan_d      = 1'b0;
                    timedout_d = 1'b1;
                    done_d     = grant_q;
                    state_d    = RESPOND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESPOND: begin
                ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign Grant    = grant_q;
    assign Done     = done_q;
    assign Result   = result_q;
    assign Zero     = zero_q;
    assign Inf      = inf_q;
    assign Nan      = nan_q;
    assign TimedOut = timedout_q;
    assign Busy     = (state_q != IDLE);
    assign AdderA   = adder_a_q;
    assign AdderB   = adder_b_q;
    assign AdderGo  = (state_q == ISSUE) || (state_q == WAIT);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Self-checking bench for fp_add_scheduler with a stub adder of programmable latency.
module tb_fp_add_scheduler;
    import floatingpointpkg::*;

    localparam int NREQ = 4;
    localparam int TMO  = 16;

    logic                  clk, rst;
    logic [NREQ-1:0]       req, grant, done;
    logic [NREQ-1:0][31:0] req_a, req_b;
    logic [31:0]           result, adder_a, adder_b, adder_result;
    logic zero, inf, nan, timed_out, busy, adder_go;
    logic adder_ready, adder_zero, adder_inf, adder_nan;

    int tests = 0;
    int fails = 0;

    int          stub_lat = 1;
    bit          stub_never = 0;
    logic        go_prev;
    int          st_cnt;
    logic        st_ready;
    logic [31:0] st_res;

    fp_add_scheduler #(
        .NREQ    (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .Req         (req),
        .ReqA        (req_a),
        .ReqB        (req_b),
        .Grant       (grant),
        .Done        (done),
        .Result      (result),
        .Zero        (zero),
        .Inf         (inf),
        .Nan         (nan),
        .TimedOut    (timed_out),
        .Busy        (busy),
        .AdderA      (adder_a),
        .AdderB      (adder_b),
        .AdderGo     (adder_go),
        .AdderResult (adder_result),
        .AdderReady  (adder_ready),
        .AdderZero   (adder_zero),
        .AdderInf    (adder_inf),
        .AdderNan    (adder_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub adder: known sums for the directed vectors, an arbitrary mix otherwise.
    function automatic logic [31:0] adder_fn(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (a[30:0] == 31'h0 && b[30:0] == 31'h0) return {a[31] & b[31], 31'h0};
        if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return 32'h7F80_0000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [2:0] flags_of(input logic [31:0] r);
        flags_of[2] = (r[30:0] == 31'h0);
        flags_of[1] = (r[30:23] == 8'hFF) && (r[22:0] == 23'h0);
        flags_of[0] = (r[30:23] == 8'hFF) && (r[22:0] != 23'h0);
    endfunction

    // Ready rises stub_lat edges after the first edge that samples Go high.
    always @(posedge clk) begin
        if (rst) begin
            go_prev  <= 1'b0;
            st_cnt   <= 0;
            st_ready <= 1'b0;
            st_res   <= '0;
        end else begin
            go_prev <= adder_go;
            if (!adder_go) begin
                st_ready <= 1'b0;
                st_cnt   <= 0;
            end else if (!go_prev) begin
                st_res <= adder_fn(adder_a, adder_b);
                if (!stub_never) begin
                    if (stub_lat <= 1) st_ready <= 1'b1;
                    else st_cnt <= stub_lat - 1;
                end
            end else if (st_cnt > 0) begin
                st_cnt <= st_cnt - 1;
                if (st_cnt == 1) st_ready <= 1'b1;
            end
        end
    end

    assign adder_result = st_res;
    assign adder_ready  = st_ready;
    assign {adder_zero, adder_inf, adder_nan} = flags_of(st_res);

    task automatic do_reset();
        rst   = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done != '0) seen = 1'b1;
        end
    endtask

    task automatic wait_grant(input int budget, output bit seen);
        int cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
            if (grant != '0) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (grant !== 4'b0 || done !== 4'b0) begin
            fails++;
            $display("FAIL reset_grant_done: got %b/%b want 0000/0000", grant, done);
        end
        tests++;
        if (result !== 32'h0) begin
            fails++;
            $display("FAIL reset_result: got %h want 00000000", result);
        end
        tests++;
        if ({zero, inf, nan, timed_out} !== 4'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 0000", {zero, inf, nan, timed_out});
        end
        tests++;
        if (busy !== 1'b0 || adder_go !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy_go: got %b%b want 00", busy, adder_go);
        end
        tests++;
        if (adder_a !== 32'h0 || adder_b !== 32'h0) begin
            fails++;
            $display("FAIL reset_adder_ops: got %h %h want 0 0", adder_a, adder_b);
        end
    endtask

    task automatic test_single();
        int cyc;
        bit seen;
        stub_lat = 1 + int'($urandom_range(0, 3));
        req_a[0] = 32'h3F80_0000;
        req_b[0] = 32'h4000_0000;
        req[0]   = 1'b1;
        wait_done(40, cyc, seen);
        tests++;
        if (done !== 4'b0001) begin
            fails++;
            $display("FAIL single_done: got %b want 0001", done);
        end
        tests++;
        if (result !== 32'h4040_0000 || {zero, inf, nan, timed_out} !== 4'b0) begin
            fails++;
            $display("FAIL single_result: got %h flags %b want 40400000 0000",
                     result, {zero, inf, nan, timed_out});
        end
        // Cycles counted inclusive of the cycle the request was first presented.
        tests++;
        if (cyc + 1 != stub_lat + 3) begin
            fails++;
            $display("FAIL single_latency: got %0d want %0d", cyc + 1, stub_lat + 3);
        end
        req[0] = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_after: done=%b grant=%b busy=%b want 0000 0000 0", done, grant,
                     busy);
        end
    endtask

    task automatic test_two();
        int cyc;
        bit seen;
        logic [31:0] a1, b1, a3, b3;
        do_reset();
        stub_lat = 2;
        a1 = $urandom; b1 = $urandom; a3 = $urandom; b3 = $urandom;
        req_a[1] = a1; req_b[1] = b1; req_a[3] = a3; req_b[3] = b3;
        req = 4'b1010;
        wait_done(40, cyc, seen);
        tests++;
        if (done !== 4'b0010 || result !== adder_fn(a1, b1)) begin
            fails++;
            $display("FAIL two_first: got %b %h want 0010 %h", done, result, adder_fn(a1, b1));
        end
        req[1] = 1'b0;
        wait_done(40, cyc, seen);
        tests++;
        if (done !== 4'b1000 || result !== adder_fn(a3, b3)) begin
            fails++;
            $display("FAIL two_second: got %b %h want 1000 %h", done, result, adder_fn(a3, b3));
        end
        // Pointer wrapped to 0, so requester 0 beats requester 1.
        req_a[0] = $urandom; req_b[0] = $urandom;
        req = 4'b0011;
        wait_done(40, cyc, seen);
        tests++;
        if (done !== 4'b0001) begin
            fails++;
            $display("FAIL two_wrap: got %b want 0001", done);
        end
        req[0] = 1'b0;
        wait_done(40, cyc, seen);
        tests++;
        if (done !== 4'b0010) begin
            fails++;
            $display("FAIL two_wrap_next: got %b want 0010", done);
        end
        req = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_special();
        int cyc;
        bit seen;
        req_a[2] = 32'h8000_0000;
        req_b[2] = 32'h0000_0000;
        req[2]   = 1'b1;
        wait_done(40, cyc, seen);
        req[2] = 1'b0;
        tests++;
        if (done !== 4'b0100 || result !== 32'h0 || {zero, inf, nan} !== 3'b100) begin
            fails++;
            $display("FAIL zero_sum: got %b %h zin=%b want 0100 00000000 100", done, result,
                     {zero, inf, nan});
        end
        @(posedge clk);
        #1;
        req_a[1] = 32'h7F7F_FFFF;
        req_b[1] = 32'h7F7F_FFFF;
        req[1]   = 1'b1;
        wait_done(40, cyc, seen);
        req[1] = 1'b0;
        tests++;
        if (done !== 4'b0010 || result !== 32'h7F80_0000 || {zero, inf, nan} !== 3'b010) begin
            fails++;
            $display("FAIL inf_sum: got %b %h zin=%b want 0010 7f800000 010", done, result,
                     {zero, inf, nan});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_timeout();
        int cyc;
        bit seen;
        logic [31:0] a3, b3;
        stub_never = 1'b1;
        req_a[2] = $urandom;
        req_b[2] = $urandom;
        req[2]   = 1'b1;
        wait_grant(20, seen);
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL timeout_grant: got no grant want grant within 20 cycles");
        end
        @(posedge clk);
        #1;
        wait_done(40, cyc, seen);
        tests++;
        if (cyc != TMO + 1 || done !== 4'b0100) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles done=%b want %0d 0100", cyc, done,
                     TMO + 1);
        end
        tests++;
        if (timed_out !== 1'b1 || result !== 32'h0 || {zero, inf, nan} !== 3'b0) begin
            fails++;
            $display("FAIL timeout_result: got to=%b %h %b want 1 00000000 000", timed_out,
                     result, {zero, inf, nan});
        end
        stub_never = 1'b0;
        stub_lat   = 3;
        a3 = $urandom; b3 = $urandom;
        req_a[3] = a3; req_b[3] = b3;
        req = 4'b1000;
        wait_done(40, cyc, seen);
        tests++;
        if (done !== 4'b1000 || timed_out !== 1'b0 || result !== adder_fn(a3, b3)) begin
            fails++;
            $display("FAIL timeout_next: got %b to=%b %h want 1000 0 %h", done, timed_out,
                     result, adder_fn(a3, b3));
        end
        req = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        int ndone = 0;
        stub_never = 1'b1;
        req_a[1] = $urandom;
        req_b[1] = $urandom;
        req[1]   = 1'b1;
        wait_grant(20, seen);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (grant !== 4'b0 || adder_go !== 1'b0 || busy !== 1'b0 || done !== 4'b0) begin
            fails++;
            $display("FAIL wait_reset_state: grant=%b go=%b busy=%b done=%b want all 0", grant,
                     adder_go, busy, done);
        end
        rst = 1'b0;
        req = '0;
        stub_never = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done != '0) ndone++;
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL wait_reset_no_done: got %0d pulses want 0", ndone);
        end
    endtask

    // Scoreboard: requesters come and go at random; each grant must follow round-robin order
    // from the sampled request vector, and each Done must carry the sum of grant-time operands.
    task automatic test_random();
        int ptr_m = 0;
        int owner = -1;
        int last;
        int ndone = 0;
        int quiet = 0;
        int exp_j, idx;
        logic [NREQ-1:0]       req_s;
        logic [NREQ-1:0][31:0] a_s, b_s;
        logic [31:0]           ea, eb, er;
        do_reset();
        req_s = '0; a_s = '0; b_s = '0; ea = '0; eb = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk);
            #1;
            quiet++;
            last = -1;
            if (owner < 0 && grant != '0) begin
                exp_j = -1;
                for (int k = 0; k < NREQ; k++) begin
                    idx = (ptr_m + k) % NREQ;
                    if (exp_j < 0 && req_s[idx[1:0]]) exp_j = idx;
                end
                tests++;
                if (exp_j < 0 || grant !== 4'(1 << exp_j)) begin
                    fails++;
                    $display("FAIL rand_grant: got %b want requester %0d (req %b ptr %0d)",
                             grant, exp_j, req_s, ptr_m);
                end
                owner = (exp_j < 0) ? 0 : exp_j;
                ea = a_s[owner[1:0]];
                eb = b_s[owner[1:0]];
                quiet = 0;
                if ($urandom_range(0, 3) == 0) req_a[owner[1:0]] = $urandom;
                if ($urandom_range(0, 3) == 0) req[owner[1:0]] = 1'b0;
            end
            if (done != '0) begin
                er = adder_fn(ea, eb);
                tests++;
                if (owner < 0 || done !== 4'(1 << owner)) begin
                    fails++;
                    $display("FAIL rand_done: got %b want requester %0d", done, owner);
                end
                tests++;
                if (result !== er || {zero, inf, nan, timed_out} !== {flags_of(er), 1'b0}) begin
                    fails++;
                    $display("FAIL rand_result: got %h %b want %h %b", result,
                             {zero, inf, nan, timed_out}, er, {flags_of(er), 1'b0});
                end
                if (owner < 0) owner = 0;
                ptr_m = (owner + 1) % NREQ;
                ndone++;
                quiet = 0;
                req[owner[1:0]]   = 1'($urandom_range(0, 1));
                req_a[owner[1:0]] = $urandom;
                req_b[owner[1:0]] = $urandom;
                stub_lat = int'($urandom_range(1, 5));
                last  = owner;
                owner = -1;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (j != owner && j != last) begin
                    if (!req[j] && $urandom_range(0, 5) == 0) begin
                        req[j]   = 1'b1;
                        req_a[j] = $urandom;
                        req_b[j] = $urandom;
                    end else if (req[j] && $urandom_range(0, 40) == 0) begin
                        req[j] = 1'b0;
                    end
                end
            end
            req_s = req;
            a_s   = req_a;
            b_s   = req_b;
            if (quiet > 60) begin
                tests++;
                fails++;
                $display("FAIL rand_stall: got no grant or done for 60 cycles want progress");
                break;
            end
        end
        tests++;
        if (ndone < 50) begin
            fails++;
            $display("FAIL rand_count: got %0d completions want at least 50", ndone);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_two();
        test_special();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end

endmodule
